// File: rtl/l1_arbiter_n_pkg.sv
// Shared types and constants for the N-channel L1-to-L2 line arbiter.
package l1_arbiter_n_pkg;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } arb_state_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

endpackage

// File: rtl/l1_arbiter_n_rr_select.sv
// Combinational N-wide priority picker. Scans the active vector upward from
// i_ptr with wrap at N_CH-1 and returns the first active index. With i_ptr
// tied to zero it degenerates to lowest-index-wins.
module l1_arbiter_n_rr_select #(
   parameter int N_CH  = 4,
   parameter int IDX_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  i_act,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   // Walk the scan order from last to first so the earliest hit overwrites.
   always_comb begin : p_pick
      logic [IDX_W:0] w_sum;
      w_sum   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
         // N_CH need not be a power of two, so wrap by explicit compare.
         if (w_sum > (IDX_W + 1)'(N_CH - 1)) begin
            w_sum = w_sum - (IDX_W + 1)'(N_CH);
         end
         if (i_act[w_sum[IDX_W-1:0]]) begin
            o_valid = 1'b1;
            o_idx   = w_sum[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/l1_arbiter_n.sv
// N-channel arbiter between L1-side line requesters and the single L2 port.
// One transaction in flight; request fields are latched at grant so the
// requester may change its inputs freely until it sees resp.
//
// state | meaning
// IDLE  | sampling requests, grant taken on the first active channel
// BUSY  | latched op driven downstream, waiting for mem_resp
// DONE  | one-cycle resp pulse to the granted channel, rr pointer advances
module l1_arbiter_n
   import l1_arbiter_n_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int LINE_W  = 256,
   parameter int ADDR_W  = 32,
   parameter int RR_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          i_req_read,
   input  logic [N_CH-1:0]          i_req_write,
   input  logic [N_CH*ADDR_W-1:0]   i_req_addr,
   input  logic [N_CH*LINE_W-1:0]   i_req_wdata,
   output logic [N_CH-1:0]          o_resp,
   output logic [LINE_W-1:0]        o_rdata,
   output logic                     o_mem_read,
   output logic                     o_mem_write,
   output logic [ADDR_W-1:0]        o_mem_address,
   output logic [LINE_W-1:0]        o_mem_wdata,
   input  logic [LINE_W-1:0]        i_mem_rdata,
   input  logic                     i_mem_resp
);

   localparam int IDX_W = $clog2(N_CH);

   arb_state_t        r_state;
   arb_state_t        w_next;
   logic [IDX_W-1:0]  r_grant;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic              r_op_write;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_wdata;
   logic [LINE_W-1:0] r_rdata;

   logic [N_CH-1:0]   w_act;
   logic [IDX_W-1:0]  w_ptr;
   logic [IDX_W-1:0]  w_gidx;
   logic              w_gvalid;
   logic [ADDR_W-1:0] w_addr_arr  [N_CH];
   logic [LINE_W-1:0] w_wdata_arr [N_CH];

   for (genvar g = 0; g < N_CH; g++) begin : g_unpack
      assign w_addr_arr[g]  = i_req_addr[g*ADDR_W +: ADDR_W];
      assign w_wdata_arr[g] = i_req_wdata[g*LINE_W +: LINE_W];
   end

   assign w_act = i_req_read | i_req_write;
   // Fixed-priority mode scans from channel 0 every time.
   assign w_ptr = (RR_MODE == ARB_RR) ? r_rr_ptr : '0;

   l1_arbiter_n_rr_select #(
      .N_CH  (N_CH),
      .IDX_W (IDX_W)
   ) u_rr_select (
      .i_act   (w_act),
      .i_ptr   (w_ptr),
      .o_idx   (w_gidx),
      .o_valid (w_gvalid)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode; DONE never looks at requests.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_gvalid) w_next = BUSY;
         BUSY:    if (i_mem_resp) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Grant latch, read-data capture and rr pointer update on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_op_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
      end else begin
         if (r_state == IDLE && w_gvalid) begin
            r_grant    <= w_gidx;
            r_op_write <= i_req_write[w_gidx];
            r_addr     <= w_addr_arr[w_gidx];
            r_wdata    <= w_wdata_arr[w_gidx];
         end
         if (r_state == BUSY && i_mem_resp && !r_op_write) begin
            r_rdata <= i_mem_rdata;
         end
         if (r_state == DONE) begin
            r_rr_ptr <= (r_grant == IDX_W'(N_CH - 1)) ? '0 : r_grant + IDX_W'(1);
         end
      end
   end

   // Completion pulse goes only to the channel that owns the transaction.
   always_comb begin
      o_resp = '0;
      if (r_state == DONE) begin
         o_resp[r_grant] = 1'b1;
      end
   end

   assign o_mem_read    = (r_state == BUSY) && !r_op_write;
   assign o_mem_write   = (r_state == BUSY) &&  r_op_write;
   assign o_mem_address = r_addr;
   assign o_mem_wdata   = r_wdata;
   assign o_rdata       = r_rdata;

endmodule
